// File: rtl/hippo_alu_operand_stage_pkg.sv
// Shared ALU types: operation encoding, operand selects, buffered operand entry and
// the write-back patch applied to entries held in the operand stage.
package hippo_alu_operand_stage_pkg;

  localparam int unsigned OPND_XLEN  = 32;
  localparam int unsigned OPND_REG_W = 5;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SLL  = 3'd1,
    ALU_SLT  = 3'd2,
    ALU_SLTU = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SRL  = 3'd5,
    ALU_OR   = 3'd6,
    ALU_AND  = 3'd7
  } ALUOp;

  typedef enum logic [1:0] {
    A_RS1  = 2'd0,
    A_PC   = 2'd1,
    A_ZERO = 2'd2
  } AluASel;

  typedef enum logic [1:0] {
    B_RS2  = 2'd0,
    B_IMM  = 2'd1,
    B_FOUR = 2'd2
  } AluBSel;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } BufState;

  typedef struct packed {
    logic [OPND_XLEN-1:0]  a;
    logic [OPND_XLEN-1:0]  b;
    ALUOp                  op;
    logic                  sub_arith;
    logic [OPND_REG_W-1:0] rd;
    logic [OPND_REG_W-1:0] rs1_idx;
    logic [OPND_REG_W-1:0] rs2_idx;
    logic                  use_rs1;
    logic                  use_rs2;
  } OperandEntry;

  // A held entry picks up a write-back to a source it actually consumes; x0 never changes.
  function automatic OperandEntry patch_entry(input OperandEntry e,
                                              input logic wb_en,
                                              input logic [OPND_REG_W-1:0] wb_rd,
                                              input logic [OPND_XLEN-1:0] wb_data);
    OperandEntry r;
    r = e;
    if (wb_en && e.use_rs1 && (e.rs1_idx != '0) && (e.rs1_idx == wb_rd)) r.a = wb_data;
    if (wb_en && e.use_rs2 && (e.rs2_idx != '0) && (e.rs2_idx == wb_rd)) r.b = wb_data;
    return r;
  endfunction

endpackage

// File: rtl/hippo_operand_mux.sv
// Capture-side operand path: write-back forwarding onto rs1/rs2, then a/b source select.
module hippo_operand_mux
  import hippo_alu_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN   = OPND_XLEN,
  parameter int unsigned REG_W  = OPND_REG_W,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic [XLEN-1:0]  i_pc,
  input  logic [REG_W-1:0] i_rs1_idx,
  input  logic [REG_W-1:0] i_rs2_idx,
  input  logic [XLEN-1:0]  i_rs1_data,
  input  logic [XLEN-1:0]  i_rs2_data,
  input  logic [XLEN-1:0]  i_imm,
  input  logic [1:0]       i_a_sel,
  input  logic [1:0]       i_b_sel,
  input  logic             i_wb_en,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic [XLEN-1:0]  o_a,
  output logic [XLEN-1:0]  o_b,
  output logic             o_use_rs1,
  output logic             o_use_rs2
);

  logic            w_fwd1;
  logic            w_fwd2;
  logic [XLEN-1:0] w_rs1v;
  logic [XLEN-1:0] w_rs2v;

  assign w_fwd1 = FWD_EN && i_wb_en && (i_wb_rd == i_rs1_idx) && (i_rs1_idx != '0);
  assign w_fwd2 = FWD_EN && i_wb_en && (i_wb_rd == i_rs2_idx) && (i_rs2_idx != '0);
  assign w_rs1v = w_fwd1 ? i_wb_data : i_rs1_data;
  assign w_rs2v = w_fwd2 ? i_wb_data : i_rs2_data;

  // Select code 3 is unassigned and falls through to the register source.
  always_comb begin
    o_a = w_rs1v;
    case (i_a_sel)
      A_PC:    o_a = i_pc;
      A_ZERO:  o_a = '0;
      default: o_a = w_rs1v;
    endcase
  end

  always_comb begin
    o_b = w_rs2v;
    case (i_b_sel)
      B_IMM:   o_b = i_imm;
      B_FOUR:  o_b = XLEN'(32'd4);
      default: o_b = w_rs2v;
    endcase
  end

  assign o_use_rs1 = (i_a_sel != A_PC) && (i_a_sel != A_ZERO);
  assign o_use_rs2 = (i_b_sel != B_IMM) && (i_b_sel != B_FOUR);

endmodule

// File: rtl/hippo_alu_operand_stage.sv
// ID->EX operand stage: forwarded operand capture into a 2-entry skid buffer feeding the ALU.
//   state    | meaning
//   ST_EMPTY | no entry held; out_valid=0, in_ready=1
//   ST_ONE   | main entry valid; out_valid=1, in_ready=1
//   ST_FULL  | main and skid valid; out_valid=1, in_ready=0
module hippo_alu_operand_stage
  import hippo_alu_operand_stage_pkg::*;
#(
  parameter int unsigned XLEN   = OPND_XLEN,
  parameter int unsigned REG_W  = OPND_REG_W,
  parameter bit          FWD_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [REG_W-1:0] in_rs1_idx,
  input  logic [REG_W-1:0] in_rs2_idx,
  input  logic [XLEN-1:0]  in_rs1_data,
  input  logic [XLEN-1:0]  in_rs2_data,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [1:0]       in_a_sel,
  input  logic [1:0]       in_b_sel,
  input  logic [2:0]       in_op,
  input  logic             in_sub_arith,
  input  logic [REG_W-1:0] in_rd,
  input  logic             wb_en,
  input  logic [REG_W-1:0] wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  a,
  output logic [XLEN-1:0]  b,
  output logic [2:0]       op,
  output logic             sub_arith,
  output logic [REG_W-1:0] rd
);

  BufState     r_state;
  BufState     w_state_nxt;
  OperandEntry r_main;
  OperandEntry r_skid;
  OperandEntry w_main_nxt;
  OperandEntry w_skid_nxt;
  OperandEntry w_main_held;
  OperandEntry w_skid_held;
  OperandEntry w_new;

  logic            w_fire_out;
  logic            w_accept;
  logic [XLEN-1:0] w_mux_a;
  logic [XLEN-1:0] w_mux_b;
  logic            w_use_rs1;
  logic            w_use_rs2;

  hippo_operand_mux #(
    .XLEN   (XLEN),
    .REG_W  (REG_W),
    .FWD_EN (FWD_EN)
  ) u_operand_mux (
    .i_pc       (in_pc),
    .i_rs1_idx  (in_rs1_idx),
    .i_rs2_idx  (in_rs2_idx),
    .i_rs1_data (in_rs1_data),
    .i_rs2_data (in_rs2_data),
    .i_imm      (in_imm),
    .i_a_sel    (in_a_sel),
    .i_b_sel    (in_b_sel),
    .i_wb_en    (wb_en),
    .i_wb_rd    (wb_rd),
    .i_wb_data  (wb_data),
    .o_a        (w_mux_a),
    .o_b        (w_mux_b),
    .o_use_rs1  (w_use_rs1),
    .o_use_rs2  (w_use_rs2)
  );

  assign in_ready   = (r_state != ST_FULL);
  assign out_valid  = (r_state != ST_EMPTY);
  assign w_fire_out = out_valid & out_ready;
  assign w_accept   = in_valid & in_ready & ~flush;

  always_comb begin
    w_new           = '0;
    w_new.a         = w_mux_a;
    w_new.b         = w_mux_b;
    w_new.op        = ALUOp'(in_op);
    w_new.sub_arith = in_sub_arith;
    w_new.rd        = in_rd;
    w_new.rs1_idx   = in_rs1_idx;
    w_new.rs2_idx   = in_rs2_idx;
    w_new.use_rs1   = w_use_rs1;
    w_new.use_rs2   = w_use_rs2;
  end

  // Patching the main entry when it is popped is invisible: it has already been presented.
  assign w_main_held = FWD_EN ? patch_entry(r_main, wb_en, wb_rd, wb_data) : r_main;
  assign w_skid_held = FWD_EN ? patch_entry(r_skid, wb_en, wb_rd, wb_data) : r_skid;

  always_comb begin
    w_state_nxt = r_state;
    w_main_nxt  = w_main_held;
    w_skid_nxt  = w_skid_held;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_main_nxt  = w_new;
        end
      end
      ST_ONE: begin
        if (w_accept && w_fire_out) begin
          w_main_nxt = w_new;
        end else if (w_accept) begin
          w_state_nxt = ST_FULL;
          w_skid_nxt  = w_new;
        end else if (w_fire_out) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (w_fire_out) begin
          w_state_nxt = ST_ONE;
          w_main_nxt  = w_skid_held;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    if (flush) w_state_nxt = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
      r_skid  <= w_skid_nxt;
    end
  end

  assign a         = r_main.a;
  assign b         = r_main.b;
  assign op        = r_main.op;
  assign sub_arith = r_main.sub_arith;
  assign rd        = r_main.rd;

endmodule
